// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

   localparam int unsigned IMEM_DATA_W = 32;
   localparam int unsigned IMEM_ADDR_W = 32;

   localparam logic [IMEM_DATA_W-1:0] IMEM_NOP = 32'h0000_0000;

   typedef struct packed {
      logic [IMEM_DATA_W-1:0] data;
      logic [IMEM_ADDR_W-1:0] addr;
      logic                   fault;
   } imem_entry_t;

endpackage

// File: rtl/imem_resp_fifo.sv
// Two-entry response buffer with flush and same-cycle push/pop.
module imem_resp_fifo
   import imem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush_i,
   input  logic        push_i,
   input  imem_entry_t push_entry_i,
   input  logic        pop_i,
   output imem_entry_t head_o,
   output logic [1:0]  count_o
);

   imem_entry_t mem_q [2];
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   logic [1:0]  count_q;
   logic [1:0]  count_d;

   always_comb begin
      count_d = count_q;
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Flush outranks both push and pop; when full, push and pop share a slot
   // because the write pointer has wrapped onto the head being retired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Synchronous instruction memory with a valid/ready fetch port and a tagged response buffer.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = "",
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_fault,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [DATA_W-1:0] prog_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  fetch_idx;
  logic              fetch_fault;
  logic [DATA_W-1:0] fetch_word;
  imem_entry_t       push_entry;
  imem_entry_t       head;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_idx] <= prog_data;
    end
  end

  assign fetch_idx   = req_addr[IDX_W+1:2];
  assign fetch_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);
  // Faulting fetches never touch the array, so an out-of-range PC cannot alias a real word.
  assign fetch_word  = fetch_fault ? DATA_W'(IMEM_NOP) : mem_q[fetch_idx];

  always_comb begin
    push_entry       = '0;
    push_entry.data  = IMEM_DATA_W'(fetch_word);
    push_entry.addr  = IMEM_ADDR_W'(req_addr);
    push_entry.fault = fetch_fault;
  end

  assign resp_valid = (count != 2'd0);
  assign pop        = resp_valid && resp_ready;
  assign req_ready  = rst_n && !flush &&
                      ((count < 2'd2) || ((count == 2'd2) && pop));
  assign push       = req_valid && req_ready;

  imem_resp_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count)
  );

  assign resp_data  = DATA_W'(head.data);
  assign resp_addr  = ADDR_W'(head.addr);
  assign resp_fault = head.fault;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed, table-driven bench for imem_fetch_port with hand-written multi-cycle sequences.
module tb_imem_fetch_port;

   localparam int unsigned DEPTH = 16;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [31:0] resp_addr;
   logic        resp_fault;
   logic        flush;
   logic        prog_we;
   logic [3:0]  prog_idx;
   logic [31:0] prog_data;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   imem_fetch_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_addr  (resp_addr),
      .resp_fault (resp_fault),
      .flush      (flush),
      .prog_we    (prog_we),
      .prog_idx   (prog_idx),
      .prog_data  (prog_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rv;
      logic [31:0] addr;
      logic        rr;
      logic        fl;
      logic        we;
      logic [3:0]  idx;
      logic [31:0] wd;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_data;
      logic [31:0] e_addr;
      logic        e_flt;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] w(int i);
      if (i < 8) return 32'h0210_8020 + 32'(i) * 32'h0021_0800;
      return 32'hA500_0000 | 32'(i);
   endfunction

   function automatic vec_t v(logic rv, logic [31:0] addr, logic rr, logic fl,
                              logic e_rdy, logic e_vld, logic [31:0] e_data,
                              logic [31:0] e_addr, logic e_flt);
      vec_t r;
      r.rv = rv; r.addr = addr; r.rr = rr; r.fl = fl;
      r.we = 1'b0; r.idx = '0; r.wd = '0;
      r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_data = e_data;
      r.e_addr = e_addr; r.e_flt = e_flt;
      return r;
   endfunction

   task automatic check(string name, int row, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
      end
   endtask

   task automatic check_head(int row, logic [31:0] d, logic [31:0] a, logic f);
      check("resp_valid", row, 64'(resp_valid), 64'(1'b1));
      check("resp_data", row, 64'(resp_data), 64'(d));
      check("resp_addr", row, 64'(resp_addr), 64'(a));
      check("resp_fault", row, 64'(resp_fault), 64'(f));
   endtask

   initial begin
      vec_t r;

      // back-to-back fetches, one response per cycle
      for (int i = 0; i < 8; i++)
         tbl.push_back(v(1, 32'(4 * i), 1, 0, 1, i != 0, (i != 0) ? w(i - 1) : 32'h0,
                         32'(4 * (i - 1)), 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 1, w(7), 28, 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0));
      // backpressure: third fetch waits, then rides the first dequeue
      tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(v(1, 4, 0, 0, 1, 1, w(0), 0, 0));
      tbl.push_back(v(1, 8, 0, 0, 0, 1, w(0), 0, 0));
      tbl.push_back(v(1, 8, 0, 0, 0, 1, w(0), 0, 0));
      tbl.push_back(v(1, 8, 1, 0, 1, 1, w(0), 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 1, w(1), 4, 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 1, w(2), 8, 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0));
      // faults: misaligned, just past the array, high address bit
      tbl.push_back(v(1, 2, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(v(1, 4 * DEPTH, 1, 0, 1, 1, 0, 2, 1));
      tbl.push_back(v(1, 32'h8000_0004, 1, 0, 1, 1, 0, 4 * DEPTH, 1));
      tbl.push_back(v(0, 0, 1, 0, 1, 1, 0, 32'h8000_0004, 1));
      tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0));
      // flush with two buffered and a request pending
      tbl.push_back(v(1, 4, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(v(1, 8, 0, 0, 1, 1, w(1), 4, 0));
      tbl.push_back(v(1, 12, 1, 1, 0, 1, w(1), 4, 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0));
      // write/read collision on word 3
      r = v(1, 12, 1, 0, 1, 0, 0, 0, 0);
      r.we = 1'b1; r.idx = 4'd3; r.wd = 32'hDEAD_BEEF;
      tbl.push_back(r);
      tbl.push_back(v(1, 12, 1, 0, 1, 1, w(3), 12, 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 1, 32'hDEAD_BEEF, 12, 0));
      tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0));

      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
      flush = 1'b0; prog_we = 1'b0; prog_idx = '0; prog_data = '0;

      @(negedge clk);
      check("reset req_ready", -1, 64'(req_ready), 64'(1'b0));
      check("reset resp_valid", -1, 64'(resp_valid), 64'(1'b0));
      check("reset resp_data", -1, 64'(resp_data), 64'h0);
      check("reset resp_addr", -1, 64'(resp_addr), 64'h0);
      check("reset resp_fault", -1, 64'(resp_fault), 64'(1'b0));
      rst_n = 1'b1;
      #1;
      check("post-reset req_ready", -1, 64'(req_ready), 64'(1'b1));

      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         prog_we = 1'b1; prog_idx = 4'(i); prog_data = w(i);
      end
      @(negedge clk);
      prog_we = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         req_valid = tbl[i].rv; req_addr = tbl[i].addr; resp_ready = tbl[i].rr;
         flush = tbl[i].fl; prog_we = tbl[i].we; prog_idx = tbl[i].idx;
         prog_data = tbl[i].wd;
         #1;
         check("req_ready", i, 64'(req_ready), 64'(tbl[i].e_rdy));
         if (tbl[i].e_vld) check_head(i, tbl[i].e_data, tbl[i].e_addr, tbl[i].e_flt);
         else check("resp_valid", i, 64'(resp_valid), 64'(1'b0));
      end

      // asynchronous reset with two entries buffered
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'd16; resp_ready = 1'b0;
      prog_we = 1'b0; flush = 1'b0;
      @(negedge clk);
      req_addr = 32'd20;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check_head(100, w(4), 16, 0);
      check("full req_ready", 100, 64'(req_ready), 64'(1'b0));
      #1 rst_n = 1'b0;
      #1;
      check("async resp_valid", 101, 64'(resp_valid), 64'(1'b0));
      check("async resp_data", 101, 64'(resp_data), 64'h0);
      check("async resp_addr", 101, 64'(resp_addr), 64'h0);
      check("async req_ready", 101, 64'(req_ready), 64'(1'b0));
      @(negedge clk);
      check("held resp_valid", 102, 64'(resp_valid), 64'(1'b0));
      rst_n = 1'b1;
      req_valid = 1'b1; req_addr = 32'd12; resp_ready = 1'b1;
      @(negedge clk);
      req_addr = 32'd16;
      #1;
      check_head(103, 32'hDEAD_BEEF, 12, 0);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check_head(104, w(4), 16, 0);
      @(negedge clk);
      check("drained resp_valid", 105, 64'(resp_valid), 64'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
